// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: machine widths, default reset vector and
// the fetch-queue entry layout.
package mips_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; DEPTH must be a power of two
// so the pointers wrap naturally.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: the storage is reset too, because the head fields must read zero
    // straight out of reset rather than whatever the array powered up with.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, legal-range check with sticky
// fault, and valid/ready glue around the fetch queue.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_WORDS  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_pc_plus4_o,
    output logic        fetch_fault_o
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(INSTR_BYTES * IMEM_WORDS);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic            full, empty, pop, push, in_range;
    fetch_entry_t    head;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i ('{instr: instr_i, pc: pc_q}),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_comb begin
        pop      = !empty && out_ready_i;
        in_range = (pc_q < PC_LIMIT);
        push     = !redirect_i && in_range && (!full || pop);
        pc_d     = pc_q;
        fault_d  = fault_q;

        // A redirect drops the word fetched at the old pc and re-arms the fault check.
        if (redirect_i) begin
            pc_d    = redirect_pc_i & ~32'h3;
            fault_d = 1'b0;
        end else begin
            if (push) begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
            if (!in_range) begin
                fault_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign pc_addr_o      = pc_q;
    assign fetch_fault_o  = fault_q;
    assign out_valid_o    = !empty;
    assign out_instr_o    = head.instr;
    assign out_pc_o       = head.pc;
    assign out_pc_plus4_o = head.pc + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases push expected deliveries,
// a negedge monitor pops and compares every accepted head.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_addr_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_pc_plus4_o;
    logic        fetch_fault_o;

    int tests = 0;
    int fails = 0;
    int delivered = 0;

    logic [31:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr, prev_pc;

    if_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2),
        .IMEM_WORDS  (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_addr_o      (pc_addr_o),
        .instr_i        (instr_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_instr_o    (out_instr_o),
        .out_pc_o       (out_pc_o),
        .out_pc_plus4_o (out_pc_plus4_o),
        .fetch_fault_o  (fetch_fault_o)
    );

    always #5 clk_i = ~clk_i;

    // Instr_Memory model: word k holds 32'h1000_0000 + k.
    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign instr_i = imem_word(pc_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_pcs(input logic [31:0] first_pc, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(first_pc + 32'(4 * i));
        end
    endtask

    // Monitor: an accepted head is one seen with valid & ready just before an edge.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery_pc", out_pc_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = exp_q.pop_front();
                delivered++;
                check("deliver_pc", out_pc_o, exp_pc);
                check("deliver_instr", out_instr_o, imem_word(exp_pc));
                check("deliver_pc_plus4", out_pc_plus4_o, exp_pc + 32'd4);
            end
        end
        if (rst_i === 1'b1 && prev_stall && out_valid_o) begin
            check("stall_stable_pc", out_pc_o, prev_pc);
            check("stall_stable_instr", out_instr_o, prev_instr);
        end
        prev_stall = (rst_i === 1'b1) && out_valid_o && !out_ready_i;
        prev_pc    = out_pc_o;
        prev_instr = out_instr_o;
    end

    initial begin
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        out_ready_i   = 1'b0;
        step();
        step();
        check("reset_pc", pc_addr_o, 32'h0);
        check("reset_valid", {31'b0, out_valid_o}, 32'h0);
        check("reset_fault", {31'b0, fetch_fault_o}, 32'h0);
        check("reset_out_instr", out_instr_o, 32'h0);
        check("reset_out_pc", out_pc_o, 32'h0);

        // Streaming, then backpressure from the third cycle.
        expect_pcs(32'h0, 2);
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        step();
        check("first_valid", {31'b0, out_valid_o}, 32'h1);
        check("pc_after_first", pc_addr_o, 32'h4);
        step();
        check("pc_stream", pc_addr_o, 32'h8);
        out_ready_i = 1'b0;
        step();
        check("fill_pc", pc_addr_o, 32'hC);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_pc_frozen", pc_addr_o, 32'hC);
            check("stall_head_pc", out_pc_o, 32'h4);
        end
        out_ready_i = 1'b1;
        step();
        check("full_pop_push_pc", pc_addr_o, 32'h10);
        check("full_pop_push_head", out_pc_o, 32'h8);
        out_ready_i = 1'b0;
        step();
        check("refill_pc", pc_addr_o, 32'h10);

        // Redirect with two entries queued; 8 and 12 must never be delivered.
        expect_pcs(32'h40, 3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0042;
        step();
        check("redirect_valid", {31'b0, out_valid_o}, 32'h0);
        check("redirect_pc_aligned", pc_addr_o, 32'h40);
        redirect_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        step();
        step();

        // Redirect together with an accepted pop of pc 0x48.
        expect_pcs(32'h70, 4);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0070;
        step();
        check("redirect_pop_valid", {31'b0, out_valid_o}, 32'h0);
        check("redirect_pop_pc", pc_addr_o, 32'h70);
        redirect_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("edge_pc_128", pc_addr_o, 32'h80);
        check("fault_not_yet", {31'b0, fetch_fault_o}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("fault_set", {31'b0, fetch_fault_o}, 32'h1);
            check("fault_no_valid", {31'b0, out_valid_o}, 32'h0);
            check("fault_pc_hold", pc_addr_o, 32'h80);
        end

        // Redirect to 0 clears the fault; fill the queue without consuming.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0;
        out_ready_i   = 1'b0;
        step();
        check("fault_cleared", {31'b0, fetch_fault_o}, 32'h0);
        check("resume_pc", pc_addr_o, 32'h0);
        redirect_i = 1'b0;
        step();
        step();
        check("resume_fill_pc", pc_addr_o, 32'h8);
        check("resume_fill_valid", {31'b0, out_valid_o}, 32'h1);

        // Reset beats redirect and handshake in the same cycle.
        rst_i         = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0055;
        out_ready_i   = 1'b1;
        step();
        check("midreset_pc", pc_addr_o, 32'h0);
        check("midreset_valid", {31'b0, out_valid_o}, 32'h0);
        check("midreset_fault", {31'b0, fetch_fault_o}, 32'h0);
        check("midreset_out_instr", out_instr_o, 32'h0);

        expect_pcs(32'h0, 3);
        rst_i      = 1'b1;
        redirect_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        out_ready_i = 1'b0;
        step();
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("delivered_count", 32'(delivered), 32'd12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
